// File: rtl/v_scan_decoder_pkg.sv
// Shared types and helpers for v_scan_decoder: operating-mode enum, prescaler width
// calculation and the active-low one-hot decode.
package v_scan_decoder_pkg;

    localparam int unsigned MAX_N    = 4;
    localparam int unsigned MAX_OUTS = 1 << MAX_N;

    typedef enum logic [1:0] {
        OP_OFF    = 2'd0,
        OP_MANUAL = 2'd1,
        OP_SCAN   = 2'd2
    } op_e;

    // Counter width for a modulo-p prescaler, never narrower than one bit.
    function automatic int unsigned presc_w(input int unsigned p);
        return (p <= 2) ? 1 : $clog2(p);
    endfunction

    function automatic logic [MAX_OUTS-1:0] onehot_l(input logic [MAX_N-1:0] idx);
        return ~(MAX_OUTS'(1) << idx);
    endfunction

endpackage

// File: rtl/v_scan_prescaler.sv
// Enable-gated modulo-PRESCALE counter with synchronous clear; o_tc flags the
// last count of each dwell.
module v_scan_prescaler
    import v_scan_decoder_pkg::*;
#(
    parameter int unsigned PRESCALE = 4
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_clr,
    input  logic i_en,
    output logic o_tc
);

    localparam int unsigned W = presc_w(PRESCALE);

    logic [W-1:0] r_cnt;

    assign o_tc = (r_cnt == W'(PRESCALE - 1));

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_en) begin
            r_cnt <= o_tc ? '0 : r_cnt + W'(1);
        end
    end

endmodule

// File: rtl/v_scan_decoder.sv
// Registered N-to-2^N active-low decoder with prescaled auto-scan.
// Optional DEC_BLANK_EN: blank Y_L on the first cycle of every scan dwell.
module v_scan_decoder
    import v_scan_decoder_pkg::*;
#(
    parameter int unsigned N        = 2,
    parameter int unsigned PRESCALE = 4
) (
    input  logic                CLK,
    input  logic                RESET,
    input  logic                G_L,
    input  logic                MODE,
    input  logic [N-1:0]        SEL,
    output logic [(1<<N)-1:0]   Y_L,
    output logic [N-1:0]        IDX,
    output logic                WRAP
);

    localparam int unsigned OUTS = 1 << N;

    op_e             w_op;
    logic            w_tc;
    logic [N-1:0]    w_idx_next;
    logic [OUTS-1:0] w_y_next;
    logic            w_wrap_next;

    logic [N-1:0]    r_idx;
    logic [OUTS-1:0] r_y_l;
    logic            r_wrap;

    v_scan_prescaler #(
        .PRESCALE (PRESCALE)
    ) u_prescaler (
        .i_clk (CLK),
        .i_rst (RESET),
        .i_clr (w_op == OP_MANUAL),
        .i_en  (w_op == OP_SCAN),
        .o_tc  (w_tc)
    );

    always_comb begin
        if (G_L)       w_op = OP_OFF;
        else if (MODE) w_op = OP_SCAN;
        else           w_op = OP_MANUAL;
    end

    // Y_L is decoded from the next index so it can never disagree with IDX.
    always_comb begin
        w_idx_next  = r_idx;
        w_y_next    = '1;
        w_wrap_next = 1'b0;
        case (w_op)
            OP_MANUAL: begin
                w_idx_next = SEL;
                w_y_next   = OUTS'(onehot_l(MAX_N'(SEL)));
            end
            OP_SCAN: begin
                if (w_tc) begin
                    w_idx_next  = r_idx + N'(1);
                    w_wrap_next = (r_idx == '1);
                end
                w_y_next = OUTS'(onehot_l(MAX_N'(w_idx_next)));
`ifdef DEC_BLANK_EN
                // Terminal count means the prescaler reloads 0: first cycle of the new dwell.
                if (w_tc) w_y_next = '1;
`endif
            end
            default: begin
                w_idx_next = r_idx;
                w_y_next   = '1;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_idx  <= '0;
            r_y_l  <= '1;
            r_wrap <= 1'b0;
        end else begin
            r_idx  <= w_idx_next;
            r_y_l  <= w_y_next;
            r_wrap <= w_wrap_next;
        end
    end

    assign Y_L  = r_y_l;
    assign IDX  = r_idx;
    assign WRAP = r_wrap;

endmodule
